dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_responder_if.sv | 36 +++
 rtl/dmem_line_array.sv | 30 +++
 rtl/dmem_responder.sv | 109 ++++++++++
 tb/tb_dmem_responder.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared widths and FSM state encoding for the data-memory responder.
package dmem_pkg;
  localparam int unsigned LINE_W  = 128;
  localparam int unsigned LADDR_W = 26;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT,
    RESP,
    TURN
  } state_e;
endpackage

// File: rtl/dmem_responder_if.sv
// Cache-to-memory line bus; addr_err exists only when DMEM_RANGE_CHK_EN is defined.
interface dmem_responder_if;
  import dmem_pkg::*;

  logic               reqD_mem;
  logic [LADDR_W-1:0] reqAddrD_mem;
  logic               reqD_cache_write;
  logic [LADDR_W-1:0] reqAddrD_write_mem;
  logic [LINE_W-1:0]  data_to_mem;
  logic               reqD_stop;
  logic [LINE_W-1:0]  data_from_mem;
  logic               read_ready_from_mem;
  logic               written_data_ack_from_mem;
  logic               busy;
`ifdef DMEM_RANGE_CHK_EN
  logic               addr_err;

  modport master (
    output reqD_mem, reqAddrD_mem, reqD_cache_write, reqAddrD_write_mem, data_to_mem, reqD_stop,
    input  data_from_mem, read_ready_from_mem, written_data_ack_from_mem, busy, addr_err
  );
  modport slave (
    input  reqD_mem, reqAddrD_mem, reqD_cache_write, reqAddrD_write_mem, data_to_mem, reqD_stop,
    output data_from_mem, read_ready_from_mem, written_data_ack_from_mem, busy, addr_err
  );
`else
  modport master (
    output reqD_mem, reqAddrD_mem, reqD_cache_write, reqAddrD_write_mem, data_to_mem, reqD_stop,
    input  data_from_mem, read_ready_from_mem, written_data_ack_from_mem, busy
  );
  modport slave (
    input  reqD_mem, reqAddrD_mem, reqD_cache_write, reqAddrD_write_mem, data_to_mem, reqD_stop,
    output data_from_mem, read_ready_from_mem, written_data_ack_from_mem, busy
  );
`endif
endinterface

// File: rtl/dmem_line_array.sv
// Single-port line storage: synchronous write, registered read that holds between reads.
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LINES = 1024
) (
  input  logic                           clk,
  input  logic                           rst_ni,
  input  logic [$clog2(DEPTH_LINES)-1:0] idx_i,
  input  logic                           we_i,
  input  logic [LINE_W-1:0]              wdata_i,
  input  logic                           re_i,
  input  logic                           rd_zero_i,
  output logic [LINE_W-1:0]              rdata_o
);
  logic [LINE_W-1:0] mem_q [DEPTH_LINES];
  logic [LINE_W-1:0] rdata_q;

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= rd_zero_i ? '0 : mem_q[idx_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency line memory responder for the data cache; DMEM_RANGE_CHK_EN enables
// out-of-range address detection (zero read data, dropped write, addr_err pulse).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned LATENCY     = 5,
  parameter int unsigned DEPTH_LINES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);
  localparam int unsigned IDX_W    = $clog2(DEPTH_LINES);
  localparam logic [7:0]  CNT_INIT = (LATENCY > 1) ? 8'(LATENCY - 2) : '0;

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               op_wr_q, op_wr_d;
  logic [LADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0]  wdata_q, wdata_d;
  logic [LADDR_W-1:0] arr_addr;
  logic               arr_we, arr_re, rd_zero, wr_block;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // cnt counts the remaining wait cycles, so RESP lands LATENCY cycles after acceptance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.reqD_cache_write) begin
          op_wr_d = 1'b1;
          addr_d  = bus.reqAddrD_write_mem;
          wdata_d = bus.data_to_mem;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY > 1) ? WR_WAIT : RESP;
        end else if (bus.reqD_mem) begin
          op_wr_d = 1'b0;
          addr_d  = bus.reqAddrD_mem;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY > 1) ? RD_WAIT : RESP;
        end
      end
      RD_WAIT: begin
        if (bus.reqD_stop)   state_d = TURN;
        else if (cnt_q == '0) state_d = RESP;
        else                  cnt_d   = cnt_q - 8'd1;
      end
      WR_WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 8'd1;
      end
      RESP:    state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // In IDLE the address is not latched yet, which matters only for LATENCY == 1 reads.
  assign arr_addr = (state_q == IDLE) ? bus.reqAddrD_mem : addr_q;
  assign arr_re   = reset && (state_d == RESP) && !op_wr_d;
  assign arr_we   = reset && (state_q == RESP) && op_wr_q && !wr_block;

`ifdef DMEM_RANGE_CHK_EN
  assign rd_zero      = |(arr_addr >> IDX_W);
  assign wr_block     = |(addr_q >> IDX_W);
  assign bus.addr_err = (state_q == RESP) && wr_block;
`else
  logic unused_hi_bits;
  assign rd_zero        = 1'b0;
  assign wr_block       = 1'b0;
  assign unused_hi_bits = ^{addr_q[LADDR_W-1:IDX_W], arr_addr[LADDR_W-1:IDX_W]};
`endif

  dmem_line_array #(
    .DEPTH_LINES(DEPTH_LINES)
  ) u_array (
    .clk      (clk),
    .rst_ni   (reset),
    .idx_i    (arr_addr[IDX_W-1:0]),
    .we_i     (arr_we),
    .wdata_i  (wdata_q),
    .re_i     (arr_re),
    .rd_zero_i(rd_zero),
    .rdata_o  (bus.data_from_mem)
  );

  assign bus.read_ready_from_mem       = (state_q == RESP) && !op_wr_q;
  assign bus.written_data_ack_from_mem = (state_q == RESP) && op_wr_q;
  assign bus.busy                      = (state_q != IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY=5, DEPTH_LINES=1024).
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int LAT = 5;
  localparam logic [127:0] D10  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D10B = 128'hFEDCBA9876543210FEDCBA9876543210;
  localparam logic [127:0] D3   = 128'hDEADBEEF00112233CAFEF00D44556677;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(
    .LATENCY    (LAT),
    .DEPTH_LINES(1024)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int rr_cyc, rr_cnt, ack_cyc, ack_cnt, overlap, idle_cyc;
  logic [127:0] rr_data;
  logic err_at_rr;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs n cycles starting in an IDLE cycle (cycle 0 = acceptance cycle).
  task automatic run(input logic wr, input logic [25:0] waddr, input logic [127:0] wdata,
                     input logic rd, input logic [25:0] raddr, input int rd_len,
                     input int stop_at, input int rst_at, input int n);
    rr_cyc = -1; rr_cnt = 0; ack_cyc = -1; ack_cnt = 0; overlap = 0; idle_cyc = -1;
    rr_data = '0; err_at_rr = 1'b0;
    bus.reqD_cache_write   = wr;
    bus.reqAddrD_write_mem = waddr;
    bus.data_to_mem        = wdata;
    bus.reqD_mem           = rd;
    bus.reqAddrD_mem       = raddr;
    for (int k = 0; k < n; k++) begin
      if (k == 1) begin
        bus.reqD_cache_write   = 1'b0;
        bus.reqAddrD_write_mem = ~waddr;
        bus.data_to_mem        = ~wdata;
      end
      if (k == rd_len) bus.reqD_mem = 1'b0;
      bus.reqD_stop = (k == stop_at);
      reset         = (k != rst_at);
      @(negedge clk);
      if (bus.read_ready_from_mem) begin
        if (rr_cnt == 0) begin
          rr_cyc  = k;
          rr_data = bus.data_from_mem;
`ifdef DMEM_RANGE_CHK_EN
          err_at_rr = bus.addr_err;
`endif
        end
        rr_cnt++;
      end
      if (bus.written_data_ack_from_mem) begin
        if (ack_cnt == 0) ack_cyc = k;
        ack_cnt++;
      end
      if (bus.read_ready_from_mem && bus.written_data_ack_from_mem) overlap++;
      if (k > 0 && !bus.busy && idle_cyc < 0) idle_cyc = k;
      @(posedge clk); #1;
    end
    reset         = 1'b1;
    bus.reqD_stop = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    bus.reqD_mem = 1'b0; bus.reqAddrD_mem = '0;
    bus.reqD_cache_write = 1'b0; bus.reqAddrD_write_mem = '0;
    bus.data_to_mem = '0; bus.reqD_stop = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset_ctrl", 128'({bus.read_ready_from_mem, bus.written_data_ack_from_mem, bus.busy}), 128'(3'b000));
    chk("reset_data", bus.data_from_mem, '0);
    @(posedge clk); #1;

    // Write line 0x10, then read it back starting in cycle 7.
    run(1'b1, 26'h10, D10, 1'b0, 26'h0, 0, -1, -1, LAT + 2);
    chk("wr_ack_cycle", 128'(ack_cyc), 128'(LAT));
    chk("wr_ack_count", 128'(ack_cnt), 128'(1));
    chk("wr_no_rr", 128'(rr_cnt), 128'(0));
    run(1'b0, 26'h0, '0, 1'b1, 26'h10, 1, -1, -1, LAT + 2);
    chk("rd_rr_cycle", 128'(rr_cyc + LAT + 2), 128'(12));
    chk("rd_rr_count", 128'(rr_cnt), 128'(1));
    chk("rd_data", rr_data, D10);
    chk("rd_data_hold", bus.data_from_mem, D10);

    // Simultaneous write and read of line 3: write first.
    run(1'b1, 26'h3, D3, 1'b1, 26'h3, LAT + 3, -1, -1, 2 * LAT + 4);
    chk("both_ack_cycle", 128'(ack_cyc), 128'(LAT));
    chk("both_rr_cycle", 128'(rr_cyc), 128'(2 * LAT + 2));
    chk("both_rd_data", rr_data, D3);
    chk("both_no_overlap", 128'(overlap), 128'(0));

    // Abort a read of line 0x10 two cycles after acceptance.
    run(1'b0, 26'h0, '0, 1'b1, 26'h10, 1, 2, -1, LAT + 2);
    chk("stop_no_rr", 128'(rr_cnt), 128'(0));
    chk("stop_idle_cycle", 128'(idle_cyc), 128'(4));
    chk("stop_data_kept", bus.data_from_mem, D3);

    // Reset during WR_WAIT: write dropped, read register cleared.
    run(1'b1, 26'h10, D10B, 1'b0, 26'h0, 0, -1, 2, LAT + 3);
    chk("rst_no_ack", 128'(ack_cnt), 128'(0));
    chk("rst_idle_cycle", 128'(idle_cyc), 128'(3));
    chk("rst_data_zero", bus.data_from_mem, '0);
    run(1'b0, 26'h0, '0, 1'b1, 26'h10, 1, -1, -1, LAT + 2);
    chk("rst_old_data", rr_data, D10);

`ifdef DMEM_RANGE_CHK_EN
    run(1'b0, 26'h0, '0, 1'b1, 26'h400, 1, -1, -1, LAT + 2);
    chk("oor_rr_cycle", 128'(rr_cyc), 128'(LAT));
    chk("oor_data_zero", rr_data, '0);
    chk("oor_addr_err", 128'(err_at_rr), 128'(1));
`else
    run(1'b0, 26'h0, '0, 1'b1, 26'h410, 1, -1, -1, LAT + 2);
    chk("alias_rr_cycle", 128'(rr_cyc), 128'(LAT));
    chk("alias_data", rr_data, D10);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
